// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// NOP pattern the memory is filled with.
package lsu_pkg;

   localparam logic [1:0]  SZ_BYTE  = 2'b00;
   localparam logic [1:0]  SZ_HALF  = 2'b01;
   localparam logic [1:0]  SZ_WORD  = 2'b10;
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load-lane extraction with sign/zero extension,
// store-lane merge into a read word, and alignment/size legality check.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  lane_i,
   input  logic        unsigned_i,
   input  logic [31:0] rword_i,
   input  logic [31:0] wdata_i,
   input  logic [1:0]  chk_size_i,
   input  logic [1:0]  chk_lane_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merged_o,
   output logic        misaligned_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v      = rword_i[{lane_i, 3'b000} +: 8];
      half_v      = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
      load_data_o = rword_i;
      merged_o    = rword_i;
      case (size_i)
         SZ_BYTE: begin
            load_data_o = unsigned_i ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
         end
         SZ_HALF: begin
            load_data_o = unsigned_i ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            if (lane_i[1]) merged_o[31:16] = wdata_i[15:0];
            else           merged_o[15:0]  = wdata_i[15:0];
         end
         default: begin
            load_data_o = rword_i;
            merged_o    = wdata_i;
         end
      endcase
   end

   // Checked against the live request so a bad access never reaches memory.
   always_comb begin
      case (chk_size_i)
         SZ_BYTE: misaligned_o = 1'b0;
         SZ_HALF: misaligned_o = chk_lane_i[0];
         SZ_WORD: misaligned_o = |chk_lane_i;
         default: misaligned_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-port bus initiator: byte/half/word loads and stores, read-modify-write
// for sub-word stores, and a per-access ack timeout.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        mem_rd_en_o,
   output logic        mem_wr_en_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   input  logic [31:0] mem_data_i,
   input  logic        mem_ack_i
);

   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   lsu_state_e  state_q,    state_d;
   logic        we_q,       we_d;
   logic [1:0]  size_q,     size_d;
   logic        uns_q,      uns_d;
   logic [31:0] addr_q,     addr_d;
   logic [31:0] wdata_q,    wdata_d;
   logic [31:0] mem_data_q, mem_data_d;
   logic [31:0] rdata_q,    rdata_d;
   logic        err_q,      err_d;
   logic [TW-1:0] timer_q,  timer_d;

   logic [31:0] load_data;
   logic [31:0] merged;
   logic        misaligned;
   logic        timeout_hit;

   lsu_align u_align (
      .size_i       (size_q),
      .lane_i       (addr_q[1:0]),
      .unsigned_i   (uns_q),
      .rword_i      (mem_data_i),
      .wdata_i      (wdata_q),
      .chk_size_i   (req_size_i),
      .chk_lane_i   (req_addr_i[1:0]),
      .load_data_o  (load_data),
      .merged_o     (merged),
      .misaligned_o (misaligned)
   );

   // Fires on the cycle whose missing ack would bring the count to the limit.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && !mem_ack_i &&
                        (timer_q == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      size_d     = size_q;
      uns_d      = uns_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      mem_data_d = mem_data_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      timer_d    = timer_q;
      case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            if (req_valid_i) begin
               we_d    = req_we_i;
               size_d  = req_size_i;
               uns_d   = req_unsigned_i;
               addr_d  = req_addr_i;
               wdata_d = req_wdata_i;
               if (misaligned) begin
                  state_d = ST_RESP;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else if (req_we_i && req_size_i == SZ_WORD) begin
                  state_d    = ST_WR;
                  mem_data_d = req_wdata_i;
               end else begin
                  state_d = ST_RD;
               end
            end
         end
         ST_RD: begin
            if (mem_ack_i) begin
               timer_d = '0;
               if (we_q) begin
                  state_d    = ST_WR;
                  mem_data_d = merged;
               end else begin
                  state_d = ST_RESP;
                  rdata_d = load_data;
                  err_d   = 1'b0;
               end
            end else if (timeout_hit) begin
               state_d = ST_RESP;
               timer_d = '0;
               rdata_d = '0;
               err_d   = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_WR: begin
            if (mem_ack_i || timeout_hit) begin
               state_d = ST_RESP;
               timer_d = '0;
               rdata_d = '0;
               err_d   = !mem_ack_i;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         we_q       <= 1'b0;
         size_q     <= SZ_BYTE;
         uns_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         mem_data_q <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         timer_q    <= '0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         mem_data_q <= mem_data_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         timer_q    <= timer_d;
      end
   end

   assign req_ready_o = (state_q == ST_IDLE);
   assign rsp_valid_o = (state_q == ST_RESP);
   assign mem_rd_en_o = (state_q == ST_RD);
   assign mem_wr_en_o = (state_q == ST_WR);
   assign mem_addr_o  = {addr_q[31:2], 2'b00};
   assign mem_data_o  = mem_data_q;
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural word memory, expected responses queued
// at issue and compared when rsp_valid_o appears.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
   logic [1:0]  req_size_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic        rsp_valid_o, rsp_err_o;
   logic [31:0] rsp_rdata_o;
   logic        mem_rd_en_o, mem_wr_en_o, mem_ack_i;
   logic [31:0] mem_addr_o, mem_data_o, mem_data_i;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
   );

   // Memory model: combinational ack and read data, write commits on acked edge.
   logic [31:0] mem [0:255];
   logic        ack_en, fill, bd_we;
   logic [7:0]  bd_idx;
   logic [31:0] bd_data;
   int          rd_cycles = 0;
   int          wr_commits = 0;

   assign mem_ack_i  = ack_en && (mem_rd_en_o || mem_wr_en_o);
   assign mem_data_i = mem[mem_addr_o[9:2]];

   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < 256; i++) mem[i] <= NOP_WORD;
      end else if (bd_we) begin
         mem[bd_idx] <= bd_data;
      end else if (mem_wr_en_o && mem_ack_i) begin
         mem[mem_addr_o[9:2]] <= mem_data_o;
      end
      if (mem_rd_en_o) rd_cycles <= rd_cycles + 1;
      if (mem_wr_en_o && mem_ack_i) wr_commits <= wr_commits + 1;
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int failures = 0;

   function automatic logic [31:0] load_model(logic [31:0] w, logic [1:0] sz,
                                              logic [1:0] lo, logic uns);
      logic [31:0] sh;
      logic [31:0] v;
      sh = w >> (8 * lo);
      if (sz == SZ_BYTE) begin
         v = sh & 32'hFF;
         if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == SZ_HALF) begin
         v = sh & 32'hFFFF;
         if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] merge_model(logic [31:0] w, logic [31:0] wd,
                                               logic [1:0] sz, logic [1:0] lo);
      logic [31:0] mask;
      mask = (sz == SZ_BYTE) ? 32'hFF : (sz == SZ_HALF) ? 32'hFFFF : 32'hFFFF_FFFF;
      mask = mask << (8 * lo);
      return (w & ~mask) | ((wd << (8 * lo)) & mask);
   endfunction

   task automatic bd_write(input logic [7:0] idx, input logic [31:0] d);
      @(negedge clk);
      bd_we = 1'b1; bd_idx = idx; bd_data = d;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   // Issues one request and waits (bounded) for its response pulse.
   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output bit got, output int lat, output logic [31:0] rd,
                         output logic er, output logic rdy1);
      @(negedge clk);
      req_valid_i = 1'b1; req_we_i = we; req_size_i = size;
      req_unsigned_i = uns; req_addr_i = addr; req_wdata_i = wdata;
      @(negedge clk);
      req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00;
      req_unsigned_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
      got = 1'b0; lat = 0; rd = '0; er = 1'b0; rdy1 = req_ready_o;
      for (int k = 1; k <= 40; k++) begin
         if (k > 1) @(negedge clk);
         if (rsp_valid_o) begin
            got = 1'b1; lat = k; rd = rsp_rdata_o; er = rsp_err_o;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks += 8;
      if (req_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready_o); end
      if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid_o); end
      if (rsp_err_o !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err_o); end
      if (mem_rd_en_o !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", mem_rd_en_o); end
      if (mem_wr_en_o !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", mem_wr_en_o); end
      if (rsp_rdata_o !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata_o); end
      if (mem_addr_o !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", mem_addr_o); end
      if (mem_data_o !== 32'h0) begin failures++; $display("FAIL reset_mem_data got=%h exp=0", mem_data_o); end
      $display("reset: ready=%b rsp_valid=%b rd=%b wr=%b", req_ready_o, rsp_valid_o, mem_rd_en_o, mem_wr_en_o);
      @(negedge clk); fill = 1'b1;
      @(negedge clk); fill = 1'b0; rst_n = 1'b1;
   endtask

   task automatic test_load_word();
      bit got; int lat; logic [31:0] rd; logic er, rdy1; exp_t x; int r0, w0;
      r0 = rd_cycles; w0 = wr_commits;
      sb.push_back('{NOP_WORD, 1'b0, 2});
      do_req(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, got, lat, rd, er, rdy1);
      x = sb.pop_front();
      $display("load_word addr=40 rdata=%h err=%b lat=%0d", rd, er, lat);
      checks += 6;
      if (!got) begin failures++; $display("FAIL load_word_rsp got=none exp=pulse"); end
      if (rd !== x.rdata) begin failures++; $display("FAIL load_word_rdata got=%h exp=%h", rd, x.rdata); end
      if (er !== x.err) begin failures++; $display("FAIL load_word_err got=%b exp=%b", er, x.err); end
      if (lat != x.lat) begin failures++; $display("FAIL load_word_lat got=%0d exp=%0d", lat, x.lat); end
      if (rdy1 !== 1'b0) begin failures++; $display("FAIL load_word_busy_ready got=%b exp=0", rdy1); end
      if (rd_cycles - r0 != 1 || wr_commits != w0) begin
         failures++; $display("FAIL load_word_strobes got=rd%0d/wr%0d exp=rd1/wr0", rd_cycles - r0, wr_commits - w0);
      end
   endtask

   task automatic test_store_byte();
      bit got; int lat; logic [31:0] rd; logic er, rdy1; exp_t x; int r0, w0;
      r0 = rd_cycles; w0 = wr_commits;
      sb.push_back('{32'h0, 1'b0, 3});
      do_req(1'b1, SZ_BYTE, 1'b0, 32'h41, 32'h1234_56AB, got, lat, rd, er, rdy1);
      x = sb.pop_front();
      $display("store_byte addr=41 mem=%h err=%b lat=%0d", mem[8'h10], er, lat);
      checks += 5;
      if (!got || er !== x.err || rd !== x.rdata) begin
         failures++; $display("FAIL store_byte_rsp got=%0d/%h/%b exp=1/%h/%b", got, rd, er, x.rdata, x.err);
      end
      if (lat != x.lat) begin failures++; $display("FAIL store_byte_lat got=%0d exp=%0d", lat, x.lat); end
      if (mem[8'h10] !== 32'h0000_AB13) begin failures++; $display("FAIL store_byte_mem got=%h exp=0000ab13", mem[8'h10]); end
      if (rd_cycles - r0 != 1) begin failures++; $display("FAIL store_byte_rd got=%0d exp=1", rd_cycles - r0); end
      if (wr_commits - w0 != 1) begin failures++; $display("FAIL store_byte_wr got=%0d exp=1", wr_commits - w0); end
   endtask

   task automatic test_stores();
      logic [31:0] a[3]  = '{32'h92, 32'h90, 32'h94};
      logic [1:0]  s[3]  = '{SZ_HALF, SZ_BYTE, SZ_WORD};
      logic [31:0] wd[3] = '{32'h1234_5678, 32'h0000_00CD, 32'hDEAD_BEEF};
      logic [31:0] e[3]  = '{32'h5678_BBBB, 32'h5678_BBCD, 32'hDEAD_BEEF};
      int          el[3] = '{3, 3, 2};
      bit got; int lat; logic [31:0] rd; logic er, rdy1; exp_t x;
      bd_write(8'h24, 32'hAAAA_BBBB);
      for (int i = 0; i < 3; i++) begin
         sb.push_back('{32'h0, 1'b0, el[i]});
         do_req(1'b1, s[i], 1'b0, a[i], wd[i], got, lat, rd, er, rdy1);
         x = sb.pop_front();
         $display("store addr=%h size=%0d mem=%h err=%b lat=%0d", a[i], s[i], mem[a[i][9:2]], er, lat);
         checks += 3;
         if (!got || er !== x.err || rd !== x.rdata) begin
            failures++; $display("FAIL store_rsp[%0d] got=%0d/%h/%b exp=1/%h/%b", i, got, rd, er, x.rdata, x.err);
         end
         if (lat != x.lat) begin failures++; $display("FAIL store_lat[%0d] got=%0d exp=%0d", i, lat, x.lat); end
         if (mem[a[i][9:2]] !== e[i]) begin failures++; $display("FAIL store_mem[%0d] got=%h exp=%h", i, mem[a[i][9:2]], e[i]); end
      end
   endtask

   task automatic test_loads();
      logic [31:0] a[8] = '{32'h82, 32'h82, 32'h81, 32'h83, 32'h82, 32'h80, 32'h82, 32'h80};
      logic [1:0]  s[8] = '{SZ_BYTE, SZ_BYTE, SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF, SZ_HALF, SZ_WORD};
      logic        u[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [31:0] e[8] = '{32'hFFFF_FF81, 32'h0000_0081, 32'h0000_007F, 32'hFFFF_FF80,
                            32'hFFFF_8081, 32'h0000_7F01, 32'h0000_8081, 32'h8081_7F01};
      bit got; int lat; logic [31:0] rd; logic er, rdy1; exp_t x;
      bd_write(8'h20, 32'h8081_7F01);
      for (int i = 0; i < 8; i++) begin
         sb.push_back('{e[i], 1'b0, 2});
         do_req(1'b0, s[i], u[i], a[i], 32'h0, got, lat, rd, er, rdy1);
         x = sb.pop_front();
         $display("load addr=%h size=%0d uns=%b rdata=%h err=%b lat=%0d", a[i], s[i], u[i], rd, er, lat);
         checks += 2;
         if (!got || rd !== x.rdata || er !== x.err) begin
            failures++; $display("FAIL load_rdata[%0d] got=%0d/%h/%b exp=1/%h/%b", i, got, rd, er, x.rdata, x.err);
         end
         if (lat != x.lat) begin failures++; $display("FAIL load_lat[%0d] got=%0d exp=%0d", i, lat, x.lat); end
      end
   endtask

   task automatic test_misaligned();
      logic [31:0] a[4] = '{32'h43, 32'h40, 32'h42, 32'h41};
      logic [1:0]  s[4] = '{SZ_HALF, 2'b11, SZ_WORD, SZ_WORD};
      logic        w[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      bit got; int lat; logic [31:0] rd; logic er, rdy1; exp_t x; int r0, w0;
      for (int i = 0; i < 4; i++) begin
         r0 = rd_cycles; w0 = wr_commits;
         sb.push_back('{32'h0, 1'b1, 1});
         do_req(w[i], s[i], 1'b0, a[i], 32'hFFFF_FFFF, got, lat, rd, er, rdy1);
         x = sb.pop_front();
         $display("misaligned addr=%h size=%0d we=%b rdata=%h err=%b lat=%0d", a[i], s[i], w[i], rd, er, lat);
         checks += 3;
         if (!got || rd !== x.rdata || er !== x.err) begin
            failures++; $display("FAIL misaligned_rsp[%0d] got=%0d/%h/%b exp=1/%h/%b", i, got, rd, er, x.rdata, x.err);
         end
         if (lat != x.lat) begin failures++; $display("FAIL misaligned_lat[%0d] got=%0d exp=%0d", i, lat, x.lat); end
         if (rd_cycles != r0 || wr_commits != w0) begin
            failures++; $display("FAIL misaligned_strobes[%0d] got=rd%0d/wr%0d exp=rd0/wr0", i, rd_cycles - r0, wr_commits - w0);
         end
      end
   endtask

   task automatic test_timeout();
      bit got; int lat; logic [31:0] rd; logic er, rdy1; exp_t x; int r0, w0;
      ack_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         r0 = rd_cycles; w0 = wr_commits;
         sb.push_back('{32'h0, 1'b1, 17});
         if (i == 0) do_req(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, got, lat, rd, er, rdy1);
         else        do_req(1'b1, SZ_BYTE, 1'b0, 32'h45, 32'h77, got, lat, rd, er, rdy1);
         x = sb.pop_front();
         $display("timeout[%0d] rdata=%h err=%b lat=%0d rd_cycles=%0d", i, rd, er, lat, rd_cycles - r0);
         checks += 4;
         if (!got || rd !== x.rdata || er !== x.err) begin
            failures++; $display("FAIL timeout_rsp[%0d] got=%0d/%h/%b exp=1/%h/%b", i, got, rd, er, x.rdata, x.err);
         end
         if (lat != x.lat) begin failures++; $display("FAIL timeout_lat[%0d] got=%0d exp=%0d", i, lat, x.lat); end
         if (rd_cycles - r0 != 16) begin failures++; $display("FAIL timeout_rd_cycles[%0d] got=%0d exp=16", i, rd_cycles - r0); end
         if (wr_commits != w0 || mem[8'h11] !== NOP_WORD) begin
            failures++; $display("FAIL timeout_mem[%0d] got=%h/wr%0d exp=%h/wr0", i, mem[8'h11], wr_commits - w0, NOP_WORD);
         end
      end
      ack_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      bit seen;
      ack_en = 1'b0;
      @(negedge clk);
      req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = SZ_BYTE;
      req_unsigned_i = 1'b0; req_addr_i = 32'h48; req_wdata_i = 32'h55;
      @(negedge clk);
      req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
      repeat (2) @(negedge clk);
      checks += 5;
      if (mem_rd_en_o !== 1'b1) begin failures++; $display("FAIL reset_mid_in_rd got=%b exp=1", mem_rd_en_o); end
      #2 rst_n = 1'b0;
      #1;
      $display("reset_mid: rd=%b wr=%b ready=%b rsp_valid=%b", mem_rd_en_o, mem_wr_en_o, req_ready_o, rsp_valid_o);
      if (mem_rd_en_o !== 1'b0 || mem_wr_en_o !== 1'b0) begin
         failures++; $display("FAIL reset_mid_strobes got=%b%b exp=00", mem_rd_en_o, mem_wr_en_o);
      end
      if (req_ready_o !== 1'b1) begin failures++; $display("FAIL reset_mid_ready got=%b exp=1", req_ready_o); end
      @(negedge clk);
      rst_n = 1'b1; ack_en = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (rsp_valid_o) seen = 1'b1;
      end
      if (seen) begin failures++; $display("FAIL reset_mid_no_rsp got=pulse exp=none"); end
      if (mem[8'h12] !== NOP_WORD) begin failures++; $display("FAIL reset_mid_mem got=%h exp=%h", mem[8'h12], NOP_WORD); end
   endtask

   task automatic test_random();
      bit got; int lat; logic [31:0] rd; logic er, rdy1; exp_t x;
      logic [7:0] idx; logic [1:0] sz, lo; logic we, uns; logic [31:0] wd, old_w, exp_w;
      for (int i = 0; i < 4; i++) bd_write(8'h30 + 8'(i), $urandom);
      for (int i = 0; i < 12; i++) begin
         idx = 8'h30 + 8'($urandom_range(0, 3));
         sz  = 2'($urandom_range(0, 2));
         lo  = (sz == SZ_BYTE) ? 2'($urandom_range(0, 3)) :
               (sz == SZ_HALF) ? 2'(2 * $urandom_range(0, 1)) : 2'b00;
         we  = 1'($urandom_range(0, 1));
         uns = 1'($urandom_range(0, 1));
         wd  = $urandom;
         old_w = mem[idx];
         exp_w = we ? merge_model(old_w, wd, sz, lo) : old_w;
         sb.push_back('{we ? 32'h0 : load_model(old_w, sz, lo, uns), 1'b0,
                        (we && sz != SZ_WORD) ? 3 : 2});
         do_req(we, sz, uns, {22'h0, idx, lo}, wd, got, lat, rd, er, rdy1);
         x = sb.pop_front();
         $display("random[%0d] we=%b size=%0d addr=%h rdata=%h err=%b lat=%0d mem=%h",
                  i, we, sz, {22'h0, idx, lo}, rd, er, lat, mem[idx]);
         checks += 3;
         if (!got || rd !== x.rdata || er !== x.err) begin
            failures++; $display("FAIL random_rsp[%0d] got=%0d/%h/%b exp=1/%h/%b", i, got, rd, er, x.rdata, x.err);
         end
         if (lat != x.lat) begin failures++; $display("FAIL random_lat[%0d] got=%0d exp=%0d", i, lat, x.lat); end
         if (mem[idx] !== exp_w) begin failures++; $display("FAIL random_mem[%0d] got=%h exp=%h", i, mem[idx], exp_w); end
      end
   endtask

   initial begin
      rst_n = 1'b0; ack_en = 1'b1; fill = 1'b0; bd_we = 1'b0; bd_idx = '0; bd_data = '0;
      req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00; req_unsigned_i = 1'b0;
      req_addr_i = '0; req_wdata_i = '0;
      test_reset();
      test_load_word();
      test_store_byte();
      test_stores();
      test_loads();
      test_misaligned();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
